// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-boxes, Rcon, GF(2^8) helpers and the key expansion.
// Used by both the encrypt and decrypt paths.
package aes_pkg;

  localparam int AES128_NR = 10;
  localparam int AES128_NK = 4;

  typedef logic [127:0]        state_t;
  typedef logic [31:0]         word_t;
  typedef logic [0:10][127:0]  rk_array_t;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    LAST  = 3'd3,
    DONE  = 3'd4,
    KSCH  = 3'd5
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic state_t add_round_key(input state_t s, input state_t k);
    return s ^ k;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // rk[0] is the cipher key itself; rk[10] is the first key applied when decrypting.
  function automatic rk_array_t key_expand(input state_t key);
    word_t     w [44];
    word_t     t;
    rk_array_t rk;
    rk = '0;
    for (int i = 0; i < AES128_NK; i++) w[i] = key[127-32*i -: 32];
    for (int i = AES128_NK; i < 44; i++) begin
      t = w[i-1];
      if (i % AES128_NK == 0) t = sub_word(rot_word(t)) ^ {RCON[i/AES128_NK-1], 24'h000000};
      w[i] = w[i-AES128_NK] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

endpackage

// File: rtl/decrypt_round_core.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless is_last selects the final-round form.
module decrypt_round_core
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         is_last,
  output logic [127:0] state_o
);

  logic [127:0] sr;
  logic [127:0] ak;
  logic [127:0] mc;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  always_comb begin
    sr = '0;
    ak = '0;
    mc = '0;
    // Byte i = 4*col + row sits at bits [127-8i -: 8]; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      ak[127-8*i -: 8] = INV_SBOX[sr[127-8*i -: 8]] ^ rk_i[127-8*i -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
    end
    state_o = is_last ? ak : mc;
  end

endmodule

// File: rtl/decrypt128.sv
// Iterative AES-128 decryptor, one inverse round per clock; recomputes whenever Message/Key change.
// DECRYPT128_KEYSCHED_REG_EN registers the key schedule (one extra edge of latency).
module decrypt128
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR,
  parameter int NK = AES128_NK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [127:0]      Message,
  input  logic [32*NK-1:0]  Key,
  output logic [127:0]      decipher,
  output logic              done
);

  fsm_t              fsm_q, fsm_d;
  logic [3:0]        round_q, round_d;
  logic [127:0]      aes_state_q, aes_state_d;
  logic [127:0]      msg_q, msg_d;
  logic [32*NK-1:0]  key_q, key_d;
  logic [127:0]      decipher_q, decipher_d;
  logic              done_q, done_d;

  rk_array_t         rk_all;
  logic [127:0]      rk_sel;
  logic [127:0]      core_out;

`ifdef DECRYPT128_KEYSCHED_REG_EN
  rk_array_t rk_q, rk_d;

  always_comb begin
    rk_d = rk_q;
    if (fsm_q == KSCH) rk_d = key_expand(key_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rk_q <= '0;
    else        rk_q <= rk_d;
  end

  assign rk_all = rk_q;
`else
  assign rk_all = key_expand(key_q);
`endif

  // round_q reaches 0 on entry to LAST, so the same index yields rk0 there.
  always_comb begin
    rk_sel = '0;
    if (round_q <= 4'd10) rk_sel = rk_all[round_q];
  end

  decrypt_round_core u_core (
    .state_i (aes_state_q),
    .rk_i    (rk_sel),
    .is_last (fsm_q == LAST),
    .state_o (core_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    aes_state_d = aes_state_q;
    msg_d       = msg_q;
    key_d       = key_q;
    decipher_d  = decipher_q;
    done_d      = done_q;
    case (fsm_q)
      LOAD: begin
        msg_d  = Message;
        key_d  = Key;
        done_d = 1'b0;
`ifdef DECRYPT128_KEYSCHED_REG_EN
        fsm_d  = KSCH;
`else
        fsm_d  = INIT;
`endif
      end
`ifdef DECRYPT128_KEYSCHED_REG_EN
      KSCH: fsm_d = INIT;
`endif
      INIT: begin
        aes_state_d = add_round_key(msg_q, rk_all[NR]);
        round_d     = 4'(NR - 1);
        fsm_d       = ROUND;
      end
      ROUND: begin
        aes_state_d = core_out;
        round_d     = round_q - 4'd1;
        if (round_q == 4'd1) fsm_d = LAST;
      end
      LAST: begin
        decipher_d = core_out;
        done_d     = 1'b1;
        fsm_d      = DONE;
      end
      DONE: begin
        if ((Message != msg_q) || (Key != key_q)) begin
          done_d = 1'b0;
          fsm_d  = LOAD;
        end
      end
      default: fsm_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= LOAD;
      round_q     <= '0;
      aes_state_q <= '0;
      msg_q       <= '0;
      key_q       <= '0;
      decipher_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      aes_state_q <= aes_state_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
      decipher_q  <= decipher_d;
      done_q      <= done_d;
    end
  end

  assign decipher = decipher_q;
  assign done     = done_q;

endmodule

// File: tb/tb_decrypt128.sv
// Bench for decrypt128: known FIPS-197 vectors plus random blocks produced by a forward AES model.
module tb_decrypt128;

`ifdef DECRYPT128_KEYSCHED_REG_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 12;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] Message;
  logic [127:0] Key;
  logic [127:0] decipher;
  logic         done;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [7:0] sb [256];
  logic [127:0] last_pt;

  always #5 clk = ~clk;

  decrypt128 dut (
    .clk      (clk),
    .reset    (reset),
    .Message  (Message),
    .Key      (Key),
    .decipher (decipher),
    .done     (done)
  );

  // ---------------- reference model: forward AES-128 from first principles ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] rk [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, f;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) rk[i] = key[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = rk[i-4+j];
      if (i % 16 == 0) begin
        f = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[f];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[4*c+r] = gmul(s[4*c+r], 8'h02) ^ gmul(s[4*c+(r+1)%4], 8'h03)
                     ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released just after an edge, so the next edge is edge 1.
  task automatic start_with_reset(input logic [127:0] m, input logic [127:0] k);
    Message = m;
    Key     = k;
    reset   = 1'b0;
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Counts edges until done rises; held clears if decipher moved before that.
  task automatic wait_done(output int edges, output logic held);
    logic [127:0] start;
    start = decipher;
    edges = 0;
    held  = 1'b1;
    while (edges < 40) begin
      step();
      edges++;
      if (done === 1'b1) break;
      if (decipher !== start) held = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    Message = C1_CT;
    Key = C1_KEY;
    repeat (2) step();
    check_cnt++; if (decipher !== 128'h0) $display("FAIL reset_plain: got %h want 0", decipher); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_fips_c1;
    int e; logic h;
    start_with_reset(C1_CT, C1_KEY);
    wait_done(e, h);
    check_cnt++; if (e != LAT) $display("FAIL c1_latency: got %0d edges want %0d", e, LAT); else pass_cnt++;
    check_cnt++; if (decipher !== C1_PT) $display("FAIL c1_plain: got %h want %h", decipher, C1_PT); else pass_cnt++;
    check_cnt++; if (h !== 1'b1) $display("FAIL c1_zero_hold: decipher moved before done, want stable 0"); else pass_cnt++;
    repeat (3) step();
    check_cnt++; if (done !== 1'b1 || decipher !== C1_PT)
      $display("FAIL c1_done_hold: got done=%b %h want done=1 %h", done, decipher, C1_PT); else pass_cnt++;
  endtask

  task automatic test_input_switch;
    int e; logic h;
    Message = B_CT;
    Key = B_KEY;
    step();
    check_cnt++; if (done !== 1'b0) $display("FAIL switch_drop: got done=%b want 0", done); else pass_cnt++;
    check_cnt++; if (decipher !== C1_PT) $display("FAIL switch_hold_first: got %h want %h", decipher, C1_PT); else pass_cnt++;
    wait_done(e, h);
    check_cnt++; if (e != LAT) $display("FAIL switch_latency: got %0d edges want %0d", e, LAT); else pass_cnt++;
    check_cnt++; if (h !== 1'b1) $display("FAIL switch_hold: decipher left %h before done", C1_PT); else pass_cnt++;
    check_cnt++; if (decipher !== B_PT) $display("FAIL switch_plain: got %h want %h", decipher, B_PT); else pass_cnt++;
  endtask

  task automatic test_zero_key;
    int e; logic h;
    start_with_reset(Z_CT, 128'h0);
    wait_done(e, h);
    check_cnt++; if (e != LAT) $display("FAIL zero_latency: got %0d edges want %0d", e, LAT); else pass_cnt++;
    check_cnt++; if (h !== 1'b1) $display("FAIL zero_hold: decipher nonzero during computation"); else pass_cnt++;
    check_cnt++; if (decipher !== 128'h0 || done !== 1'b1)
      $display("FAIL zero_plain: got done=%b %h want done=1 0", done, decipher); else pass_cnt++;
  endtask

  task automatic test_midrun_change;
    int e; logic h;
    logic [127:0] new_pt, new_ct;
    new_pt = rand128();
    new_ct = aes_encrypt(new_pt, C1_KEY);
    start_with_reset(C1_CT, C1_KEY);
    repeat (4) step();
    Message = new_ct;
    wait_done(e, h);
    check_cnt++; if (4 + e != LAT) $display("FAIL midrun_latency: got %0d edges want %0d", 4 + e, LAT); else pass_cnt++;
    check_cnt++; if (decipher !== C1_PT) $display("FAIL midrun_old_plain: got %h want %h", decipher, C1_PT); else pass_cnt++;
    step();
    check_cnt++; if (done !== 1'b0) $display("FAIL midrun_drop: got done=%b want 0", done); else pass_cnt++;
    wait_done(e, h);
    check_cnt++; if (e != LAT) $display("FAIL midrun_new_latency: got %0d edges want %0d", e, LAT); else pass_cnt++;
    check_cnt++; if (decipher !== new_pt) $display("FAIL midrun_new_plain: got %h want %h", decipher, new_pt); else pass_cnt++;
    last_pt = new_pt;
  endtask

  task automatic test_async_reset;
    int e; logic h;
    Message = B_CT;
    Key = B_KEY;
    repeat (6) step();
    check_cnt++; if (decipher !== last_pt) $display("FAIL async_prior_hold: got %h want %h", decipher, last_pt); else pass_cnt++;
    #3;
    reset = 1'b0;
    #1;
    check_cnt++; if (decipher !== 128'h0) $display("FAIL async_clear_plain: got %h want 0", decipher); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL async_clear_done: got %b want 0", done); else pass_cnt++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_done(e, h);
    check_cnt++; if (e != LAT) $display("FAIL async_latency: got %0d edges want %0d", e, LAT); else pass_cnt++;
    check_cnt++; if (decipher !== B_PT) $display("FAIL async_plain: got %h want %h", decipher, B_PT); else pass_cnt++;
  endtask

  task automatic test_random;
    int e; logic h;
    logic [127:0] k, pt, ct;
    for (int n = 0; n < 8; n++) begin
      k  = rand128();
      pt = rand128();
      ct = aes_encrypt(pt, k);
      if (n % 2 == 0) begin
        Message = ct;
        Key = k;
        step();
      end else begin
        start_with_reset(ct, k);
      end
      wait_done(e, h);
      check_cnt++; if (e != LAT) $display("FAIL rand%0d_latency: got %0d edges want %0d", n, e, LAT); else pass_cnt++;
      check_cnt++; if (decipher !== pt) $display("FAIL rand%0d_plain: got %h want %h", n, decipher, pt); else pass_cnt++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    Message = '0;
    Key     = '0;
    last_pt = '0;
    build_sbox();
    test_reset();
    test_fips_c1();
    test_input_switch();
    test_zero_key();
    test_midrun_change();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
